// File: rtl/led_cfg_pkg.sv
// Shared types and helpers for the LED divider configuration arbiter.
// Holds the FSM state encoding, default divider settings and the zero-clamp rule.
package led_cfg_pkg;

  localparam int DIV_W_DEF = 5;
  localparam int DIV_RST_DEF = 24;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DECPL  = 3'd4,
    ST_REPLAY = 3'd5
  } state_t;

  // A divider of zero would stall the LED counter, so it is written as one.
  // Works on a 16-bit container; callers zero-extend and truncate.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/led_cfg_arb_rr_arb.sv
// Combinational round-robin winner search: first set request bit after ptr,
// wrapping modulo N.
module rr_arb #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] win_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    any     = |req;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        win_idx = IW'(idx);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_cfg_arb.sv
// Arbitrates rate-limited divider writes onto the LED counter config port,
// holding off during PR decouple and replaying the last divider afterwards.
module led_cfg_arb
  import led_cfg_pkg::*;
#(
  parameter int               NUM_REQ  = 3,
  parameter int               DIV_W    = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_RST_DEF),
  parameter int               HOLD_CYC = 16
) (
  input  logic                     clk100,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*DIV_W-1:0] div_req_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  input  logic                     decouple_i,
  output logic [DIV_W-1:0]         div_o,
  output logic                     wren_o,
  output logic [DIV_W-1:0]         cur_div_o,
  output logic                     busy_o,
  output state_t                   state_dbg
);

  // Handshake: req_i[k] is a level held until gnt_o[k] pulses for one cycle;
  // the write to the counter happens in that same cycle (wren_o=1).

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 2);

  state_t               state, nxt;
  logic [IW-1:0]        ptr, win;
  logic [DIV_W-1:0]     win_div, div_q, cur_q, div_sel, req_div;
  logic [CW-1:0]        cnt;
  logic                 any, wren;
  logic [IW-1:0]        win_idx;
  logic [NUM_REQ-1:0]   gnt;

  rr_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arb (
    .req     (req_i),
    .ptr     (ptr),
    .any     (any),
    .win_idx (win_idx)
  );

  assign req_div = div_req_i[int'(win_idx)*DIV_W +: DIV_W];

  always_comb begin
    nxt     = state;
    wren    = 1'b0;
    gnt     = '0;
    div_sel = div_q;
    case (state)
      ST_INIT: begin
        if (decouple_i) begin
          nxt = ST_DECPL;
        end else begin
          wren    = 1'b1;
          div_sel = DIV_RST;
          nxt     = ST_HOLD;
        end
      end
      ST_IDLE: begin
        if (decouple_i)  nxt = ST_DECPL;
        else if (any)    nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (decouple_i) begin
          nxt = ST_DECPL;
        end else begin
          wren    = 1'b1;
          div_sel = win_div;
          gnt     = NUM_REQ'(1) << win;
          nxt     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Exiting at cnt==1 gives HOLD_CYC-2 hold cycles between WRITE and IDLE.
        if (decouple_i)          nxt = ST_DECPL;
        else if (cnt <= CW'(1))  nxt = ST_IDLE;
      end
      ST_DECPL: begin
        if (!decouple_i) nxt = ST_REPLAY;
      end
      ST_REPLAY: begin
        if (decouple_i) begin
          nxt = ST_DECPL;
        end else begin
          wren    = 1'b1;
          div_sel = cur_q;
          nxt     = ST_HOLD;
        end
      end
      default: nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_INIT;
      ptr     <= IW'(NUM_REQ - 1);
      win     <= '0;
      win_div <= DIV_RST;
      div_q   <= DIV_RST;
      cur_q   <= DIV_RST;
      cnt     <= '0;
    end else begin
      state <= nxt;
      if (nxt == ST_HOLD && state != ST_HOLD) begin
        cnt <= HOLD_LOAD;
      end else if (state == ST_HOLD && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (state == ST_IDLE && nxt == ST_WRITE) begin
        win     <= win_idx;
        win_div <= DIV_W'(clamp_div(16'(req_div)));
      end
      if (wren) begin
        div_q <= div_sel;
      end
      if (state == ST_WRITE && !decouple_i) begin
        cur_q <= win_div;
        ptr   <= win;
      end
    end
  end

  // The INIT strobe is combinational on state, so it is held off while reset is low.
  assign wren_o    = wren & rstn;
  assign gnt_o     = gnt;
  assign div_o     = div_sel;
  assign cur_div_o = cur_q;
  assign busy_o    = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_led_cfg_arb.sv
// Self-checking bench for led_cfg_arb: directed scenarios pinned with literals,
// then random traffic checked each cycle against a schedule-based model.
module tb_led_cfg_arb;
  import led_cfg_pkg::*;

  localparam int N  = 3;
  localparam int DW = 5;
  localparam int HC = 16;
  localparam logic [DW-1:0] DRST = 5'd24;

  logic            clk100 = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] div_req_i;
  logic [N-1:0]    gnt_o;
  logic            decouple_i;
  logic [DW-1:0]   div_o;
  logic            wren_o;
  logic [DW-1:0]   cur_div_o;
  logic            busy_o;
  state_t          state_dbg;

  led_cfg_arb #(
    .NUM_REQ  (N),
    .DIV_W    (DW),
    .DIV_RST  (DRST),
    .HOLD_CYC (HC)
  ) dut (
    .clk100     (clk100),
    .rstn       (rstn),
    .req_i      (req_i),
    .div_req_i  (div_req_i),
    .gnt_o      (gnt_o),
    .decouple_i (decouple_i),
    .div_o      (div_o),
    .wren_o     (wren_o),
    .cur_div_o  (cur_div_o),
    .busy_o     (busy_o),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int            c;
    logic [N-1:0]  g;
    logic [DW-1:0] d;
  } strobe_t;

  strobe_t       st_q[$];
  int            fall_q[$];
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  last_gnt = '0;
  logic          prev_busy = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a schedule of the next strobe and the cycle from
  // which the block is free again, driven by decouple stretches.
  int            m_free_at, m_act_at, m_kind, m_ptr, m_win;
  bit            m_dec;
  logic [DW-1:0] m_val, m_div, m_cur;
  logic          e_wren, e_busy;
  logic [N-1:0]  e_gnt;
  bit            m_wrote;

  always @(negedge clk100) begin
    cyc++;
    e_wren  = 1'b0;
    e_gnt   = '0;
    e_busy  = 1'b1;
    m_wrote = 1'b0;
    if (!rstn) begin
      m_dec = 0; m_free_at = 0; m_kind = 1; m_act_at = cyc + 1;
      m_val = DRST; m_div = DRST; m_cur = DRST; m_ptr = N - 1;
    end else if (m_dec) begin
      if (!decouple_i) begin
        m_dec = 0; m_kind = 1; m_act_at = cyc + 1; m_val = m_cur;
      end
    end else if (m_kind != 0 && m_act_at == cyc) begin
      if (decouple_i) begin
        m_dec = 1; m_kind = 0;
      end else begin
        e_wren = 1'b1;
        m_div  = m_val;
        if (m_kind == 2) begin
          e_gnt   = N'(1) << m_win;
          m_wrote = 1'b1;
        end
        m_free_at = cyc + HC - 1;
        m_kind    = 0;
      end
    end else if (cyc < m_free_at) begin
      if (decouple_i) m_dec = 1;
    end else begin
      e_busy = 1'b0;
      if (decouple_i) begin
        m_dec = 1;
      end else if (req_i != '0) begin
        m_win = -1;
        for (int i = 1; i <= N; i++)
          if (m_win < 0 && req_i[(m_ptr + i) % N]) m_win = (m_ptr + i) % N;
        m_val    = div_req_i[m_win*DW +: DW];
        if (m_val == '0) m_val = 1;
        m_kind   = 2;
        m_act_at = cyc + 1;
      end
    end

    n_checks++;
    if (wren_o !== e_wren || gnt_o !== e_gnt || busy_o !== e_busy ||
        div_o !== m_div || cur_div_o !== m_cur) begin
      n_fail++;
      $display("FAIL cycle_cmp @%0d: wren=%b/%b gnt=%b/%b busy=%b/%b div=%0d/%0d cur=%0d/%0d (got/req)",
               cyc, wren_o, e_wren, gnt_o, e_gnt, busy_o, e_busy, div_o, m_div, cur_div_o, m_cur);
    end
    if (m_wrote) begin
      m_cur = m_val;
      m_ptr = m_win;
    end

    if (wren_o) st_q.push_back('{c: cyc, g: gnt_o, d: div_o});
    if (rstn && prev_busy && !busy_o) fall_q.push_back(cyc);
    prev_busy = busy_o;
    last_gnt  = gnt_o;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk100);
      #2;
    end
  endtask

  task automatic step();
    tick(1);
    for (int k = 0; k < N; k++) if (last_gnt[k]) req_i[k] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (busy_o == 1'b0) break;
      step();
    end
  endtask

  int rel;

  initial begin
    rstn = 1'b0; req_i = '0; div_req_i = '0; decouple_i = 1'b0;
    tick(3);

    // Reset release: INIT strobe with 24, then idle HC-1 cycles after it.
    st_q.delete(); fall_q.delete();
    rstn = 1'b1;
    rel  = cyc + 1;
    tick(20);
    check("init_strobe_count", st_q.size(), 1);
    if (st_q.size() >= 1) begin
      check("init_strobe_cycle", st_q[0].c, rel);
      check("init_strobe_div", int'(st_q[0].d), 24);
      check("init_no_grant", int'(st_q[0].g), 0);
    end
    check("init_idle_count", fall_q.size(), 1);
    if (fall_q.size() >= 1) check("init_idle_cycle", fall_q[0], rel + HC - 1);

    // Continuous requests from all three: strict rotation, HC spacing.
    st_q.delete();
    div_req_i = {5'd9, 5'd7, 5'd3};
    req_i     = 3'b111;
    for (int i = 0; i < 100; i++) begin
      if (st_q.size() >= 4) break;
      tick(1);
    end
    req_i = '0;
    exp_q = '{5'd3, 5'd7, 5'd9, 5'd3};
    check("rot_count", st_q.size(), 4);
    if (st_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("rot_gnt", int'(st_q[i].g), 1 << (i % 3));
        check("rot_div", int'(st_q[i].d), int'(exp_q.pop_front()));
        if (i > 0) check("rot_spacing", st_q[i].c - st_q[i-1].c, HC);
      end
    end
    tick(1);
    check("rot_cur", int'(cur_div_o), 3);

    // Zero divider is clamped to one.
    st_q.delete();
    div_req_i[9:5] = 5'd0;
    req_i = 3'b010;
    for (int i = 0; i < 60; i++) begin
      if (st_q.size() >= 1) break;
      step();
    end
    check("clamp_count", st_q.size(), 1);
    if (st_q.size() >= 1) begin
      check("clamp_gnt", int'(st_q[0].g), 3'b010);
      check("clamp_div", int'(st_q[0].d), 1);
    end
    tick(2);
    check("clamp_cur", int'(cur_div_o), 1);

    // Decouple in the WRITE cycle: no strobe, replay on release, then grant.
    wait_idle();
    st_q.delete();
    div_req_i[14:10] = 5'd11;
    req_i = 3'b100;
    tick(1);
    decouple_i = 1'b1;
    tick(50);
    check("decpl_silent", st_q.size(), 0);
    decouple_i = 1'b0;
    rel = cyc + 1;
    for (int i = 0; i < 40; i++) step();
    check("replay_count", st_q.size(), 2);
    if (st_q.size() >= 2) begin
      check("replay_cycle", st_q[0].c, rel + 1);
      check("replay_div", int'(st_q[0].d), 1);
      check("replay_no_grant", int'(st_q[0].g), 0);
      check("post_replay_gnt", int'(st_q[1].g), 3'b100);
      check("post_replay_div", int'(st_q[1].d), 11);
      check("post_replay_spacing", st_q[1].c - st_q[0].c, HC);
    end

    // Decouple toggling 1-0-1-0: a single replay after the final release.
    wait_idle();
    st_q.delete();
    rel = cyc + 1;
    decouple_i = 1'b1; tick(1);
    decouple_i = 1'b0; tick(1);
    decouple_i = 1'b1; tick(1);
    decouple_i = 1'b0; tick(20);
    check("toggle_count", st_q.size(), 1);
    if (st_q.size() >= 1) begin
      check("toggle_cycle", st_q[0].c, rel + 4);
      check("toggle_div", int'(st_q[0].d), 11);
    end

    // Reset during HOLD with requests pending.
    wait_idle();
    st_q.delete();
    div_req_i = {5'd20, 5'd13, 5'd6};
    req_i = 3'b111;
    for (int i = 0; i < 40; i++) begin
      if (st_q.size() >= 1) break;
      step();
    end
    req_i[0] = 1'b1;
    tick(3);
    rstn = 1'b0;
    #1;
    check("rst_wren", int'(wren_o), 0);
    check("rst_gnt", int'(gnt_o), 0);
    check("rst_busy", int'(busy_o), 1);
    check("rst_div", int'(div_o), 24);
    check("rst_cur", int'(cur_div_o), 24);
    tick(2);
    st_q.delete();
    rstn = 1'b1;
    rel = cyc + 1;
    for (int i = 0; i < 60; i++) begin
      if (st_q.size() >= 2) break;
      step();
    end
    check("rst_restart_count", st_q.size(), 2);
    if (st_q.size() >= 2) begin
      check("rst_init_cycle", st_q[0].c, rel);
      check("rst_init_div", int'(st_q[0].d), 24);
      check("rst_first_gnt", int'(st_q[1].g), 3'b001);
      check("rst_first_div", int'(st_q[1].d), 6);
      check("rst_first_cycle", st_q[1].c, rel + HC);
    end

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (!req_i[k] && $urandom_range(0, 7) == 0) begin
          div_req_i[k*DW +: DW] = DW'($urandom_range(0, 31));
          req_i[k] = 1'b1;
        end
      end
      if ($urandom_range(0, 39) == 0) decouple_i = ~decouple_i;
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 1499) == 0) rstn = 1'b0;
    end
    decouple_i = 1'b0;
    req_i = '0;
    tick(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
